// File: rtl/ov5640_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ov5640_cfg_pkg
// Description : Shared types and constants for the OV5640 register-table
//               configuration sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package ov5640_cfg_pkg;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_REQ    = 4'd3,
        S_WAIT   = 4'd4,
        S_DELAY  = 4'd5,
        S_NEXT   = 4'd6,
        S_DONE   = 4'd7,
        S_FAIL   = 4'd8
    } cfg_state_t;

    localparam logic [31:0] END_MARKER = 32'hFFFF_FFFF;
    localparam logic [7:0]  SKIP_DEV0  = 8'h00;
    localparam logic [7:0]  SKIP_DEVF  = 8'hFF;
    localparam logic [15:0] SWRST_REG  = 16'h3008;

    // Divide first so the intermediate product stays inside 32 bits.
    function automatic int unsigned delay_cycles(input int unsigned clk_freq,
                                                 input int unsigned delay_us);
        return (clk_freq / 1_000_000) * delay_us;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ov5640_cfg_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : ov5640_cfg_sequencer_if
// Description : Write-request handshake between the sequencer and I2C master.
// Revision    : 1.0 - initial release
// ============================================================================
interface ov5640_cfg_sequencer_if;

    logic        wr_req;
    logic [7:0]  wr_dev;
    logic [15:0] wr_reg;
    logic [7:0]  wr_data;
    logic        wr_done;
    logic        wr_err;

    modport master (
        output wr_req,
        output wr_dev,
        output wr_reg,
        output wr_data,
        input  wr_done,
        input  wr_err
    );

    modport slave (
        input  wr_req,
        input  wr_dev,
        input  wr_reg,
        input  wr_data,
        output wr_done,
        output wr_err
    );

endinterface
`default_nettype wire

// File: rtl/ov5640_cfg_sequencer_delay_timer.sv
`default_nettype none
// ============================================================================
// Module      : cfg_delay_timer
// Description : Loadable down-counter; expired while the count sits at zero.
// Revision    : 1.0 - initial release
// ============================================================================
module cfg_delay_timer #(
    parameter int unsigned WIDTH = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_load,
    input  wire logic [WIDTH-1:0] i_load_val,
    input  wire logic             i_count_en,
    output logic                  o_expired
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_count_en && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_expired = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/ov5640_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : ov5640_cfg_sequencer
// Description : Walks an external register table and issues I2C writes, with
//               retry on NACK and a settle delay after software reset.
// Revision    : 1.0 - initial release
// ============================================================================
module ov5640_cfg_sequencer
    import ov5640_cfg_pkg::*;
#(
    parameter int unsigned CLK_FREQ     = 50_000_000,
    parameter int unsigned RST_DELAY_US = 5000,
    parameter logic [9:0]  LUT_MAX      = 10'd1023,
    parameter int unsigned MAX_RETRY    = 3
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    input  wire logic                 start,
    output logic [9:0]                lut_index,
    input  wire logic [31:0]          lut_data,
    ov5640_cfg_sequencer_if.master    wr_bus,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    output logic [9:0]                wr_count
);

    localparam int unsigned c_delay_cycles = delay_cycles(CLK_FREQ, RST_DELAY_US);
    localparam int unsigned c_dly_w        = (c_delay_cycles > 1) ? $clog2(c_delay_cycles) : 1;
    // Timer is loaded with N-1 and DELAY leaves on zero, so DELAY spans N cycles.
    localparam logic [c_dly_w-1:0] c_dly_load =
        (c_delay_cycles > 1) ? c_dly_w'(c_delay_cycles - 1) : '0;
    localparam int unsigned c_retry_w      = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [c_retry_w-1:0] c_retry_limit = c_retry_w'(MAX_RETRY);

    cfg_state_t           r_state;
    cfg_state_t           w_state_next;
    logic [31:0]          r_entry;
    logic [c_retry_w-1:0] r_retry;
    logic [9:0]           r_lut_index;
    logic [9:0]           r_wr_count;
    logic                 r_wr_req;
    logic [7:0]           r_wr_dev;
    logic [15:0]          r_wr_reg;
    logic [7:0]           r_wr_data;

    logic                 w_accept;
    logic                 w_load_entry;
    logic                 w_issue;
    logic                 w_wait_end;
    logic                 w_ack;
    logic                 w_retry;
    logic                 w_advance;
    logic                 w_dly_load;
    logic                 w_dly_count_en;
    logic                 w_dly_expired;
    logic                 w_skip_dev;
    logic                 w_is_swrst;

    assign w_skip_dev     = (lut_data[31:24] == SKIP_DEV0) || (lut_data[31:24] == SKIP_DEVF);
    assign w_is_swrst     = (r_wr_reg == SWRST_REG) && r_wr_data[7];
    assign w_dly_count_en = (r_state == S_DELAY);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_load_entry = 1'b0;
        w_issue      = 1'b0;
        w_wait_end   = 1'b0;
        w_ack        = 1'b0;
        w_retry      = 1'b0;
        w_advance    = 1'b0;
        w_dly_load   = 1'b0;
        unique case (r_state)
            S_IDLE, S_DONE, S_FAIL: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                w_state_next = S_DECODE;
            end
            S_DECODE: begin
                w_load_entry = 1'b1;
                if (lut_data == END_MARKER) begin
                    w_state_next = S_DONE;
                end else if (w_skip_dev) begin
                    w_state_next = S_NEXT;
                end else begin
                    w_state_next = S_REQ;
                end
            end
            S_REQ: begin
                w_issue      = 1'b1;
                w_state_next = S_WAIT;
            end
            S_WAIT: begin
                // A NACK wins over a simultaneous ACK.
                if (wr_bus.wr_err) begin
                    w_wait_end = 1'b1;
                    if (r_retry < c_retry_limit) begin
                        w_retry      = 1'b1;
                        w_state_next = S_REQ;
                    end else begin
                        w_state_next = S_FAIL;
                    end
                end else if (wr_bus.wr_done) begin
                    w_wait_end = 1'b1;
                    w_ack      = 1'b1;
                    if (w_is_swrst) begin
                        w_dly_load   = 1'b1;
                        w_state_next = S_DELAY;
                    end else begin
                        w_state_next = S_NEXT;
                    end
                end
            end
            S_DELAY: begin
                if (w_dly_expired) begin
                    w_state_next = S_NEXT;
                end
            end
            S_NEXT: begin
                w_advance    = 1'b1;
                w_state_next = (r_lut_index == LUT_MAX) ? S_DONE : S_FETCH;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_entry     <= '0;
            r_retry     <= '0;
            r_lut_index <= '0;
            r_wr_count  <= '0;
            r_wr_req    <= 1'b0;
            r_wr_dev    <= '0;
            r_wr_reg    <= '0;
            r_wr_data   <= '0;
        end else begin
            if (w_accept) begin
                r_lut_index <= '0;
                r_wr_count  <= '0;
                r_retry     <= '0;
            end
            if (w_load_entry) begin
                r_entry <= lut_data;
            end
            // Payload is (re)loaded on every issue so a retry resends the same entry.
            if (w_issue) begin
                r_wr_req  <= 1'b1;
                r_wr_dev  <= r_entry[31:24];
                r_wr_reg  <= r_entry[23:8];
                r_wr_data <= r_entry[7:0];
            end else if (w_wait_end) begin
                r_wr_req <= 1'b0;
            end
            if (w_ack) begin
                r_wr_count <= r_wr_count + 1'b1;
            end
            if (w_retry) begin
                r_retry <= r_retry + 1'b1;
            end
            if (w_advance) begin
                r_retry <= '0;
                if (r_lut_index != LUT_MAX) begin
                    r_lut_index <= r_lut_index + 1'b1;
                end
            end
        end
    end

    cfg_delay_timer #(
        .WIDTH      (c_dly_w)
    ) u_delay_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_dly_load),
        .i_load_val (c_dly_load),
        .i_count_en (w_dly_count_en),
        .o_expired  (w_dly_expired)
    );

    assign lut_index      = r_lut_index;
    assign wr_count       = r_wr_count;
    assign wr_bus.wr_req  = r_wr_req;
    assign wr_bus.wr_dev  = r_wr_dev;
    assign wr_bus.wr_reg  = r_wr_reg;
    assign wr_bus.wr_data = r_wr_data;
    assign busy           = (r_state != S_IDLE) && (r_state != S_DONE) && (r_state != S_FAIL);
    assign done           = (r_state == S_DONE);
    assign error          = (r_state == S_FAIL);

endmodule
`default_nettype wire

// File: tb/tb_ov5640_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ov5640_cfg_sequencer
// Description : Self-checking bench: directed table vectors, random tables
//               against a table-walk model, reset and LUT_MAX corner cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ov5640_cfg_sequencer;

    localparam int unsigned CLK_FREQ     = 1_000_000;
    localparam int unsigned RST_DELAY_US = 20;
    localparam int unsigned MAX_RETRY    = 3;
    localparam int          N_DLY        = 20;   // RST_DELAY_US * CLK_FREQ / 1e6
    localparam int          TBL_N        = 16;
    localparam int          N_VEC        = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        start2 = 1'b0;
    logic [9:0]  lut_index, lut_index2, wr_count, wr_count2;
    logic [31:0] lut_data, lut_data2;
    logic        busy, done, error, busy2, done2, error2;

    logic [31:0] tbl  [TBL_N];
    logic [31:0] tbl2 [5];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ov5640_cfg_sequencer_if bus ();
    ov5640_cfg_sequencer_if bus2 ();

    assign lut_data  = (lut_index < 10'd16) ? tbl[lut_index[3:0]] : 32'hFFFF_FFFF;
    assign lut_data2 = (lut_index2 < 10'd5) ? tbl2[lut_index2[2:0]] : 32'hFFFF_FFFF;

    ov5640_cfg_sequencer #(
        .CLK_FREQ(CLK_FREQ), .RST_DELAY_US(RST_DELAY_US), .LUT_MAX(10'd15), .MAX_RETRY(MAX_RETRY)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .lut_index(lut_index), .lut_data(lut_data),
        .wr_bus(bus), .busy(busy), .done(done), .error(error), .wr_count(wr_count)
    );

    ov5640_cfg_sequencer #(
        .CLK_FREQ(CLK_FREQ), .RST_DELAY_US(RST_DELAY_US), .LUT_MAX(10'd4), .MAX_RETRY(MAX_RETRY)
    ) dut_small (
        .clk(clk), .rst(rst), .start(start2), .lut_index(lut_index2), .lut_data(lut_data2),
        .wr_bus(bus2), .busy(busy2), .done(done2), .error(error2), .wr_count(wr_count2)
    );

    // I2C master stand-in for the main DUT: plan[] decides NACK per attempt.
    int          lat = 10;
    bit          plan [80];
    int          att_idx = 0;
    logic        spur_done = 1'b0;
    logic        spur_err = 1'b0;
    logic [31:0] obs [$];
    int          req_cyc [$];
    int          ack_cyc [$];

    initial begin
        bus.wr_done = 1'b0;
        bus.wr_err  = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.wr_req === 1'b1) begin
                obs.push_back({bus.wr_dev, bus.wr_reg, bus.wr_data});
                req_cyc.push_back(cyc);
                repeat (lat - 1) @(negedge clk);
                if (bus.wr_req === 1'b1) begin
                    if (att_idx < 80 && plan[att_idx]) bus.wr_err = 1'b1;
                    else                               bus.wr_done = 1'b1;
                    att_idx++;
                    ack_cyc.push_back(cyc);
                    @(negedge clk);
                    bus.wr_done = 1'b0;
                    bus.wr_err  = 1'b0;
                end
            end else begin
                bus.wr_done = spur_done;
                bus.wr_err  = spur_err;
            end
        end
    end

    logic [31:0] obs2 [$];
    initial begin
        bus2.wr_done = 1'b0;
        bus2.wr_err  = 1'b0;
        forever begin
            @(negedge clk);
            if (bus2.wr_req === 1'b1) begin
                obs2.push_back({bus2.wr_dev, bus2.wr_reg, bus2.wr_data});
                repeat (2) @(negedge clk);
                bus2.wr_done = 1'b1;
                @(negedge clk);
                bus2.wr_done = 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: walk the table by its rules, consuming one plan bit per attempt.
    logic [31:0] exp_wr [$];
    int          exp_count, exp_idx;
    bit          exp_done, exp_err;

    task automatic model_walk();
        int att;
        int retry;
        logic [7:0] dev;
        att = 0;
        exp_wr.delete();
        exp_count = 0; exp_done = 0; exp_err = 0; exp_idx = 0;
        for (int i = 0; i < TBL_N; i++) begin
            exp_idx = i;
            dev = tbl[i][31:24];
            if (tbl[i] == 32'hFFFF_FFFF) begin
                exp_done = 1;
                return;
            end
            if (dev == 8'h00 || dev == 8'hFF) continue;
            retry = 0;
            forever begin
                exp_wr.push_back(tbl[i]);
                if (plan[att++]) begin
                    if (retry == MAX_RETRY) begin
                        exp_err = 1;
                        return;
                    end
                    retry++;
                end else begin
                    exp_count++;
                    break;
                end
            end
        end
        exp_done = 1;
    endtask

    task automatic run_walk(input string name);
        int cnt;
        obs.delete(); req_cyc.delete(); ack_cyc.delete();
        att_idx = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk({name, " busy"}, {31'd0, busy}, 32'd1);
        chk({name, " done clr"}, {30'd0, done, error}, 32'd0);
        cnt = 0;
        while (!(done || error) && cnt < 20000) begin
            @(negedge clk);
            cnt++;
        end
        chk({name, " finish"}, {31'd0, done | error}, 32'd1);
        @(negedge clk);
        model_walk();
        chk({name, " nwrites"}, obs.size(), exp_wr.size());
        for (int i = 0; i < exp_wr.size(); i++)
            if (i < obs.size()) chk($sformatf("%s write%0d", name, i), obs[i], exp_wr[i]);
        chk({name, " wr_count"}, {22'd0, wr_count}, exp_count);
        chk({name, " done"}, {31'd0, done}, {31'd0, exp_done});
        chk({name, " error"}, {31'd0, error}, {31'd0, exp_err});
        chk({name, " idle"}, {31'd0, busy}, 32'd0);
        chk({name, " lut_index"}, {22'd0, lut_index}, exp_idx);
    endtask

    typedef struct packed {
        logic [15:0] errs;
        logic [3:0]  lat;
        logic [9:0]  cnt;
        logic        dn;
        logic        er;
        logic [9:0]  idx;
    } vec_t;

    vec_t        vecs [N_VEC];
    logic [31:0] vtab [N_VEC][TBL_N];

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        for (int k = 0; k < N_VEC; k++)
            for (int i = 0; i < TBL_N; i++) vtab[k][i] = 32'hFFFF_FFFF;
        // Vendor reset sequence: write 2 is a software reset with bit 7 set.
        vtab[0][0] = 32'h7831_0311; vtab[0][1] = 32'h7830_0882; vtab[0][2] = 32'h7830_0842;
        vecs[0] = '{errs: 16'h0000, lat: 4'd10, cnt: 10'd3, dn: 1'b1, er: 1'b0, idx: 10'd3};
        vtab[1][0] = 32'h7831_0311; vtab[1][1] = 32'h0012_3456; vtab[1][2] = 32'hFF30_0882;
        vtab[1][3] = 32'h7830_0812;
        vecs[1] = '{errs: 16'h0000, lat: 4'd4, cnt: 10'd2, dn: 1'b1, er: 1'b0, idx: 10'd4};
        for (int i = 0; i < 6; i++) vtab[2][i] = 32'h7843_0000 | (i + 1);
        vecs[2] = '{errs: 16'h0020, lat: 4'd3, cnt: 10'd6, dn: 1'b1, er: 1'b0, idx: 10'd6};
        vtab[3][0] = 32'h7831_0311; vtab[3][1] = 32'h7831_0422;
        vecs[3] = '{errs: 16'h001E, lat: 4'd2, cnt: 10'd1, dn: 1'b0, er: 1'b1, idx: 10'd1};
        vecs[4] = '{errs: 16'h0000, lat: 4'd2, cnt: 10'd0, dn: 1'b1, er: 1'b0, idx: 10'd0};
        for (int i = 0; i < TBL_N; i++) vtab[5][i] = 32'h7850_0000 | (i << 8) | i;
        vecs[5] = '{errs: 16'h0000, lat: 4'd1, cnt: 10'd16, dn: 1'b1, er: 1'b0, idx: 10'd15};
        for (int i = 0; i < 5; i++) tbl2[i] = 32'h7860_0000 | (i << 8) | (i + 8'h10);
        for (int i = 0; i < TBL_N; i++) tbl[i] = 32'hFFFF_FFFF;

        repeat (3) @(negedge clk);
        chk("rst wr_req", {31'd0, bus.wr_req}, 32'd0);
        chk("rst status", {29'd0, busy, done, error}, 32'd0);
        chk("rst lut_index", {22'd0, lut_index}, 32'd0);
        chk("rst payload", {bus.wr_dev, bus.wr_reg, bus.wr_data}, 32'd0);
        chk("rst wr_count", {22'd0, wr_count}, 32'd0);
        rst = 1'b0;

        // Completion pulses with no request outstanding must do nothing.
        @(negedge clk); spur_done = 1'b1; spur_err = 1'b1;
        repeat (2) @(negedge clk); spur_done = 1'b0; spur_err = 1'b0;
        repeat (2) @(negedge clk);
        chk("spurious wr_count", {22'd0, wr_count}, 32'd0);
        chk("spurious status", {29'd0, busy, done, error}, 32'd0);

        for (int k = 0; k < N_VEC; k++) begin
            for (int i = 0; i < TBL_N; i++) tbl[i] = vtab[k][i];
            for (int i = 0; i < 80; i++) plan[i] = (i < 16) ? vecs[k].errs[i] : 1'b0;
            lat = int'(vecs[k].lat);
            run_walk($sformatf("v%0d", k));
            chk($sformatf("v%0d vec count", k), {22'd0, wr_count}, {22'd0, vecs[k].cnt});
            chk($sformatf("v%0d vec status", k), {30'd0, done, error}, {30'd0, vecs[k].dn, vecs[k].er});
            chk($sformatf("v%0d vec index", k), {22'd0, lut_index}, {22'd0, vecs[k].idx});
            if (k == 0 && ack_cyc.size() >= 2 && req_cyc.size() >= 3) begin
                chk("v0 gap plain", req_cyc[1] - ack_cyc[0], 5);
                chk("v0 gap swrst", req_cyc[2] - ack_cyc[1], N_DLY + 5);
            end
        end

        for (int r = 0; r < 15; r++) begin
            for (int i = 0; i < TBL_N; i++) begin
                int x;
                x = $urandom_range(0, 99);
                if (x < 6)       tbl[i] = 32'hFFFF_FFFF;
                else if (x < 11) tbl[i] = {8'h00, 24'($urandom)};
                else if (x < 16) tbl[i] = {8'hFF, 24'($urandom)};
                else tbl[i] = {8'($urandom_range(1, 254)),
                               ($urandom_range(0, 5) == 0) ? 16'h3008 : 16'($urandom),
                               8'($urandom)};
            end
            for (int i = 0; i < 80; i++) plan[i] = ($urandom_range(0, 4) == 0);
            lat = $urandom_range(1, 6);
            run_walk($sformatf("rnd%0d", r));
        end

        // Reset while the second write is outstanding.
        for (int i = 0; i < TBL_N; i++) tbl[i] = vtab[0][i];
        for (int i = 0; i < 80; i++) plan[i] = 1'b0;
        lat = 10;
        obs.delete();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        cnt = 0;
        while (!(bus.wr_req === 1'b1 && obs.size() == 2) && cnt < 2000) begin
            @(negedge clk);
            cnt++;
        end
        chk("rst-wait reached", {31'd0, bus.wr_req}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("midrst wr_req", {31'd0, bus.wr_req}, 32'd0);
        chk("midrst status", {29'd0, busy, done, error}, 32'd0);
        chk("midrst lut_index", {22'd0, lut_index}, 32'd0);
        chk("midrst wr_count", {22'd0, wr_count}, 32'd0);
        chk("midrst payload", {bus.wr_dev, bus.wr_reg, bus.wr_data}, 32'd0);
        @(negedge clk); rst = 1'b0;
        repeat (12) @(negedge clk);
        run_walk("after rst");

        // No end marker, LUT_MAX=4; a start mid-walk must not restart it.
        @(negedge clk); start2 = 1'b1;
        @(negedge clk); start2 = 1'b0;
        repeat (8) @(negedge clk); start2 = 1'b1;
        @(negedge clk); start2 = 1'b0;
        cnt = 0;
        while (!(done2 || error2) && cnt < 2000) begin
            @(negedge clk);
            cnt++;
        end
        chk("small done", {30'd0, done2, error2}, 32'd2);
        chk("small nwrites", obs2.size(), 5);
        for (int i = 0; i < 5; i++)
            if (i < obs2.size()) chk($sformatf("small write%0d", i), obs2[i], tbl2[i]);
        chk("small wr_count", {22'd0, wr_count2}, 32'd5);
        chk("small lut_index", {22'd0, lut_index2}, 32'd4);
        chk("small busy", {31'd0, busy2}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
